// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared constants and state type for the task scheduler arbiter
package sched_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - lowest-index-wins one-hot picker with binary index encoder
module prio_pick
    import sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [N_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_onehot = '0;
        o_id     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_id        = ID_W'(i);
            end
        end
    end

    assign o_any = |i_vec;
endmodule

// File: rtl/task_arbiter.sv
// rtl/task_arbiter.sv - eight-way quantum-bounded arbiter with starvation promotion
module task_arbiter
    import sched_pkg::*;
#(
    parameter int QUANTUM      = 16,
    parameter int STARVE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);
    state_t              r_state, w_state_nx;
    logic [N_REQ-1:0]    r_gnt, w_gnt_nx;
    logic [ID_W-1:0]     r_gnt_id, w_gnt_id_nx;
    logic [CNT_W-1:0]    r_qcnt, w_qcnt_nx;
    logic                r_mask, w_mask_nx;
    logic [ID_W-1:0]     r_last_id, w_last_id_nx;
    logic                r_preempt, w_preempt_nx;
    logic [CNT_W-1:0]    r_wait [N_REQ];

    logic [N_REQ-1:0]    w_last_oh;
    logic [N_REQ-1:0]    w_cand;
    logic [N_REQ-1:0]    w_starved;
    logic [N_REQ-1:0]    w_oh_s, w_oh_n;
    logic [ID_W-1:0]     w_id_s, w_id_n;
    logic                w_any_s, w_any_n;
    logic                w_others;

    // The previous preempted holder steps aside only if someone else is asking.
    assign w_last_oh = N_REQ'(1) << r_last_id;
    assign w_cand    = (r_mask && |(req & ~w_last_oh)) ? (req & ~w_last_oh) : req;
    assign w_others  = |(req & ~r_gnt);

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_starved[i] = w_cand[i] && (r_wait[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    prio_pick u_pick_starved (
        .i_vec    (w_starved),
        .o_onehot (w_oh_s),
        .o_id     (w_id_s),
        .o_any    (w_any_s)
    );

    prio_pick u_pick_normal (
        .i_vec    (w_cand),
        .o_onehot (w_oh_n),
        .o_id     (w_id_n),
        .o_any    (w_any_n)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_gnt_nx     = r_gnt;
        w_gnt_id_nx  = r_gnt_id;
        w_qcnt_nx    = r_qcnt;
        w_mask_nx    = r_mask;
        w_last_id_nx = r_last_id;
        w_preempt_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_n) begin
                    w_state_nx  = S_GRANT;
                    w_gnt_nx    = w_any_s ? w_oh_s : w_oh_n;
                    w_gnt_id_nx = w_any_s ? w_id_s : w_id_n;
                    w_qcnt_nx   = CNT_W'(1);
                    w_mask_nx   = 1'b0;
                end
            end
            S_GRANT: begin
                if (done[r_gnt_id] || !req[r_gnt_id]) begin
                    w_state_nx  = S_IDLE;
                    w_gnt_nx    = '0;
                    w_gnt_id_nx = '0;
                    w_qcnt_nx   = '0;
                end else if (r_qcnt == CNT_W'(QUANTUM)) begin
                    if (w_others) begin
                        w_state_nx   = S_IDLE;
                        w_gnt_nx     = '0;
                        w_gnt_id_nx  = '0;
                        w_qcnt_nx    = '0;
                        w_mask_nx    = 1'b1;
                        w_last_id_nx = r_gnt_id;
                        w_preempt_nx = 1'b1;
                    end else begin
                        w_qcnt_nx = CNT_W'(1);
                    end
                end else begin
                    w_qcnt_nx = r_qcnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_qcnt    <= '0;
            r_mask    <= 1'b0;
            r_last_id <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_gnt_nx;
            r_gnt_id  <= w_gnt_id_nx;
            r_qcnt    <= w_qcnt_nx;
            r_mask    <= w_mask_nx;
            r_last_id <= w_last_id_nx;
            r_preempt <= w_preempt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] || r_gnt[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != CNT_W'(STARVE_LIMIT)) begin
                    r_wait[i] <= r_wait[i] + CNT_W'(1);
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = |r_gnt;
    assign preempt   = r_preempt;
endmodule
